// File: rtl/mux_n_stream.sv
// N-channel valid/ready stream multiplexer with a single registered output beat.
// Channel selection is either an external index (manual) or a rotating round-robin scan.
module mux_n_stream #(
    parameter int WIDTH = 3,
    parameter int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Handshake: an input beat k moves when in_valid[k] & in_ready[k] at a rising
    // edge; the output beat is consumed when out_valid & out_ready at a rising edge.

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    logic             load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             take;

    assign load = ~out_valid_q | out_ready;

    always_comb begin
        int idx;
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        idx        = 0;
        if (mode == 1'b0) begin
            // An out-of-range sel simply matches no channel.
            for (int k = 0; k < N; k++) begin
                if (sel == SEL_W'(k) && in_valid[k]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'(k);
                    grant_data = in_data[k*WIDTH +: WIDTH];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= N) idx = idx - N;
                if (!grant_vld && in_valid[idx]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = SEL_W'(idx);
                    grant_data = in_data[idx*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign take = grant_vld & load & rst_n;

    always_comb begin
        in_ready = '0;
        if (take) in_ready[grant_idx] = 1'b1;
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (take) begin
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            if (mode) begin
                rr_ptr_d = (grant_idx == SEL_W'(N-1)) ? '0 : grant_idx + SEL_W'(1);
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_stream.sv
// Bench for mux_n_stream: directed scenarios plus random traffic against a
// transaction-level model of the output register and round-robin pointer.
module tb_mux_n_stream;

    localparam int W = 3;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic           mode;
    logic [1:0]     sel;
    logic [W-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_valid;
    logic           out_ready;

    // Second instance with a non-power-of-two channel count.
    logic           rst3_n;
    logic [3*W-1:0] in_data3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic           mode3;
    logic [1:0]     sel3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_ch3;
    logic           out_valid3;
    logic           out_ready3;

    int checks = 0;
    int errors = 0;

    // Model state: the beat the consumer currently sees, and the next rr start point.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch;
    int           m_ptr;

    always #5 clk = ~clk;

    mux_n_stream #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_n_stream #(.WIDTH(W), .N(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Channel chosen this cycle, or -1: manual takes sel if it names a valid
    // channel; rr takes the valid channel closest after the pointer, cyclically.
    function automatic int ref_grant(input logic [N-1:0] v, input logic md,
                                     input int s, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = N;
        if (!md) begin
            if (s < N && v[s]) best = s;
        end else begin
            for (int k = 0; k < N; k++) begin
                d = (k - ptr + N) % N;
                if (v[k] && d < bestd) begin
                    best  = k;
                    bestd = d;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [W-1:0] ch_data(input int k);
        logic [N*W-1:0] d;
        d = in_data;
        return d[k*W +: W];
    endfunction

    // One clock: check outputs mid-cycle, then advance the model across the edge.
    task automatic cycle(input string tag);
        int g;
        logic ld;
        logic [N-1:0] er;
        @(negedge clk);
        ld = !m_valid || out_ready;
        g  = ref_grant(in_valid, mode, int'(sel), m_ptr);
        er = '0;
        if (g >= 0 && ld && rst_n) er[g] = 1'b1;
        chk({tag, "/in_ready"},  32'(in_ready),  32'(er));
        chk({tag, "/out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, "/out_data"},  32'(out_data),  32'(m_data));
        chk({tag, "/out_ch"},    32'(out_ch),    32'(m_ch));
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        end else if (g >= 0 && ld) begin
            m_valid = 1'b1;
            m_data  = ch_data(g);
            m_ch    = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0;
        rst3_n = 1'b0; in_data3 = '0; in_valid3 = '0; mode3 = 1'b0; sel3 = '0; out_ready3 = 1'b1;

        // Reset with every channel requesting.
        rst_n = 1'b0; in_valid = 4'b1111; out_ready = 1'b1; mode = 1'b0; sel = 2'd0;
        in_data = 12'($urandom);
        cycle("rst0");
        cycle("rst1");
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/out_data",  32'(out_data),  32'd0);

        // Manual sel=2, all valid: only channel 2 is granted.
        rst_n = 1'b1; mode = 1'b0; sel = 2'd2;
        in_data = {3'd7, 3'b011, 3'd5, 3'd6};
        for (int i = 0; i < 3; i++) begin
            cycle("man");
            chk("man/out_data", 32'(out_data), 32'd3);
            chk("man/out_ch",   32'(out_ch),   32'd2);
        end

        // Round-robin, all valid, channel k carries k+1.
        mode = 1'b1;
        in_data = {3'd4, 3'd3, 3'd2, 3'd1};
        for (int i = 0; i < 8; i++) begin
            cycle("rr_all");
            chk("rr_all/out_ch",   32'(out_ch),   32'(i % 4));
            chk("rr_all/out_data", 32'(out_data), 32'(i % 4 + 1));
        end

        // Round-robin over channels 1 and 3 only, then drain.
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle("rr_13");
            chk("rr_13/out_ch", 32'(out_ch), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        in_valid = 4'b0000;
        cycle("drain");
        chk("drain/out_valid", 32'(out_valid), 32'd0);

        // Backpressure for three cycles, then release.
        in_valid = 4'b1111;
        cycle("bp_fill");
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            chk("bp_hold/out_ch", 32'(out_ch), 32'd0);
        end
        out_ready = 1'b1;
        cycle("bp_rel");
        chk("bp_rel/out_ch", 32'(out_ch), 32'd1);

        // Random traffic with occasional resets and mode/sel switches.
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 99) >= 3);
            in_data   = 12'($urandom);
            in_valid  = 4'($urandom);
            mode      = 1'($urandom);
            sel       = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        // N=3: sel=3 names no channel.
        rst3_n = 1'b1; in_valid3 = 3'b111; in_data3 = {3'd6, 3'd5, 3'd4}; sel3 = 2'd3;
        @(posedge clk); #1;
        @(negedge clk);
        chk("n3_sel3/in_ready",  32'(in_ready3),  32'd0);
        chk("n3_sel3/out_valid", 32'(out_valid3), 32'd0);
        sel3 = 2'd1;
        @(negedge clk);
        chk("n3_sel1/in_ready", 32'(in_ready3), 32'b010);
        @(posedge clk); #1;
        chk("n3_sel1/out_valid", 32'(out_valid3), 32'd1);
        chk("n3_sel1/out_data",  32'(out_data3),  32'd5);
        rst3_n = 1'b0;
        @(negedge clk);
        chk("n3_rst/in_ready", 32'(in_ready3), 32'd0);
        @(posedge clk); #1;
        chk("n3_rst/out_valid", 32'(out_valid3), 32'd0);
        chk("n3_rst/out_data",  32'(out_data3),  32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
